// File: rtl/vector_shift_sequencer.sv
// Multi-cycle vector shift stage: one lane per cycle through a single WIDTH-bit
// barrel shifter, with the assembled result held for a valid/ready consumer.
module vector_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_vec,
  input  logic [WIDTH-1:0]       in_shamt,
  input  logic                   in_dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_vec,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and every output here is a
  // register, so no input reaches an output combinationally.

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);
  localparam logic [WIDTH:0] SHAMT_LIMIT = (WIDTH + 1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [LANES*WIDTH-1:0] src_q;
  logic [WIDTH-1:0]       shamt_q;
  logic                   dir_q;
  logic [LANES*WIDTH-1:0] out_vec_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  logic [WIDTH-1:0] cur_lane;
  logic [WIDTH-1:0] shifted;

  // Oversized amounts are forced to zero explicitly rather than relying on
  // the shift operator's behaviour for large operands.
  always_comb begin
    cur_lane = src_q[int'(cnt_q)*WIDTH +: WIDTH];
    if ({1'b0, shamt_q} >= SHAMT_LIMIT) begin
      shifted = '0;
    end else if (dir_q) begin
      shifted = cur_lane >> shamt_q;
    end else begin
      shifted = cur_lane << shamt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src_q       <= '0;
      shamt_q     <= '0;
      dir_q       <= 1'b0;
      out_vec_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            src_q      <= in_vec;
            shamt_q    <= in_shamt;
            dir_q      <= in_dir;
            cnt_q      <= '0;
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          out_vec_q[int'(cnt_q)*WIDTH +: WIDTH] <= shifted;
          if (cnt_q == LAST_LANE) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // in_ready returns one cycle after the result leaves, so a result
          // handshake and a new accept never share an edge.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_vector_shift_sequencer.sv
// Directed bench for vector_shift_sequencer: hand-computed shift results,
// latency/throughput, backpressure, reset abort and back-to-back ordering.
module tb_vector_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int VW    = LANES * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_vec;
  logic [7:0]    in_shamt;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vec;
  logic          busy;
  logic [1:0]    state_dbg;

  vector_shift_sequencer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_shamt  (in_shamt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  int            rise_log[$];
  int            tests = 0;
  int            fails = 0;
  int            accept_cycle = 0;
  logic          ov_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    tests++;
    if (obs !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, expected, cyc);
    end
  endtask

  // Drivers change signals exactly on the falling edge; the monitor looks
  // 2ns later, i.e. at values that the next rising edge will act on.
  always @(negedge clk) begin
    #2;
    if (out_valid && !ov_prev) rise_log.push_back(cyc);
    ov_prev = out_valid;
    if (out_valid && out_ready && !rst) begin
      check("result_pending", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) check("result_vec", out_vec, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_op(input logic [VW-1:0] v, input logic [7:0] s, input logic d,
                          input bit hold);
    int n = 0;
    in_vec = v; in_shamt = s; in_dir = d; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1 accept_cycle = cyc;
    @(negedge clk);
    if (!hold) begin
      // Scramble operands after the accept: the latched copy must be used.
      in_valid = 1'b0;
      in_vec   = VW'($urandom);
      in_shamt = 8'($urandom_range(0, 255));
      in_dir   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 32'(out_valid), 32'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- directed vectors ----------------
  // Source 0x01FF801B: lanes (3..0) = 01 FF 80 1B, left-shifted by index.
  logic [7:0]    sweep_sh  [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd255};
  logic [VW-1:0] sweep_exp [10] = '{32'h01FF801B, 32'h02FE0036, 32'h04FC006C, 32'h08F800D8,
                                    32'h10F000B0, 32'h20E00060, 32'h40C000C0, 32'h80800080,
                                    32'h00000000, 32'h00000000};

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_shamt = '0; in_dir = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_out_vec",   out_vec,        32'h0);
    check("rst_state",     32'(state_dbg), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Left by 1 with latency measurement (accept cycle counted as cycle 1).
    exp_q.push_back(32'h02FE0036);
    issue_op(32'h01FF801B, 8'd1, 1'b0, 1'b0);
    check("busy_in_shift", 32'(busy), 32'(1));
    wait_out_valid();
    lat = cyc - accept_cycle + 1;
    check("latency", 32'(lat), 32'(LANES + 1));
    check("busy_in_done", 32'(busy), 32'(1));
    wait_drain();

    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(sweep_exp[i]);
      issue_op(32'h01FF801B, sweep_sh[i], 1'b0, 1'b0);
      wait_drain();
    end

    // Right shifts and a second source vector (lanes 80 C3 7F 01).
    exp_q.push_back(32'h001F1003); issue_op(32'h01FF801B, 8'd3, 1'b1, 1'b0); wait_drain();
    exp_q.push_back(32'h01FF801B); issue_op(32'h01FF801B, 8'd0, 1'b1, 1'b0); wait_drain();
    exp_q.push_back(32'h00000000); issue_op(32'h01FF801B, 8'd8, 1'b1, 1'b0); wait_drain();
    exp_q.push_back(32'h01010000); issue_op(32'h80C37F01, 8'd7, 1'b1, 1'b0); wait_drain();
    exp_q.push_back(32'h0030F010); issue_op(32'h80C37F01, 8'd4, 1'b0, 1'b0); wait_drain();

    // Backpressure: hold the result for 4 cycles while the inputs wiggle.
    out_ready = 1'b0;
    exp_q.push_back(32'h001F1003);
    issue_op(32'h01FF801B, 8'd3, 1'b1, 1'b0);
    wait_out_valid();
    for (int k = 0; k < 4; k++) begin
      in_vec   = VW'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_out_vec",   out_vec,         32'h001F1003);
      check("bp_out_valid", 32'(out_valid),  32'(1));
      check("bp_in_ready",  32'(in_ready),   32'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_after", 32'(in_ready),  32'(1));
    check("bp_valid_after", 32'(out_valid), 32'(0));
    check("bp_vec_held",    out_vec,        32'h001F1003);
    wait_drain();

    // Reset after two lanes of a left-by-1 on 0x01FF801B are written.
    issue_op(32'h01FF801B, 8'd1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("partial_lanes", 32'(out_vec[15:0]), 32'h0036);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state",     32'(state_dbg), 32'(0));
    check("abort_out_vec",   out_vec,        32'h0);
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_in_ready",  32'(in_ready),  32'(1));
    check("abort_busy",      32'(busy),      32'(0));
    @(negedge clk);
    exp_q.push_back(32'h0030F010);
    issue_op(32'h80C37F01, 8'd4, 1'b0, 1'b0);
    wait_drain();

    // Back-to-back with in_valid and out_ready kept high.
    rise_log.delete();
    exp_q.push_back(32'h02FE0036);
    exp_q.push_back(32'h01010000);
    exp_q.push_back(32'h001F1003);
    issue_op(32'h01FF801B, 8'd1, 1'b0, 1'b1);
    issue_op(32'h80C37F01, 8'd7, 1'b1, 1'b1);
    issue_op(32'h01FF801B, 8'd3, 1'b1, 1'b0);
    wait_drain();
    check("b2b_results", 32'(rise_log.size()), 32'(3));
    if (rise_log.size() == 3) begin
      check("b2b_gap_1", 32'(rise_log[1] - rise_log[0]), 32'(LANES + 2));
      check("b2b_gap_2", 32'(rise_log[2] - rise_log[1]), 32'(LANES + 2));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vector_shift_sequencer.md
# vector_shift_sequencer

Multi-cycle vector shift stage for the vector execute path. Accepts a packed vector of `LANES` elements, a shared shift amount and a direction, then shifts one lane per cycle through a single `WIDTH`-bit barrel shifter. Results are assembled in an output register and handed downstream over a valid/ready handshake. It is the sequencing stage that directly feeds and consumes the combinational left-shift unit, with right shifts added for the vector ISA.

## Interface
- `WIDTH`, default 8: bits per lane; also the width of the shift-amount operand.
- `LANES`, default 4: number of lanes per vector; must be ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `in_valid`  in  1  upstream presents an operation.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `in_vec`  in  LANES*WIDTH  source vector; lane i at bits [i*WIDTH +: WIDTH].
- `in_shamt`  in  WIDTH  unsigned shift amount, applied to every lane.
- `in_dir`  in  1  0 = logical left, 1 = logical right.
- `out_valid`  out  1  `out_vec` holds a complete result.
- `out_ready`  in  1  downstream accepts the result.
- `out_vec`  out  LANES*WIDTH  shifted vector, same lane packing as `in_vec`.
- `busy`  out  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `in_vec`, `in_shamt` and `in_dir`; clear the lane counter to 0; go to SHIFT.
- SHIFT:
  - Each cycle, shift source lane[counter] by the latched amount and direction.
  - Write the result to `out_vec` lane[counter] and increment the counter.
  - After writing lane LANES-1, go to DONE.
- DONE:
  - `out_valid`=1.
  - On `out_valid`&`out_ready`, go to IDLE.
  - `out_vec` is held until the next operation overwrites it lane by lane.
- Arithmetic:
  - Logical shifts only; vacated bits are zero-filled.
  - Any `in_shamt` ≥ WIDTH yields 0 for every lane, in both directions.
  - Shift amount 0 passes data unchanged.
- Inputs are ignored outside the IDLE handshake cycle; latched operands are immune to later input changes.
- No overlap: a new operation is not accepted in the cycle the result handshake completes. `in_ready` rises the following cycle.
- Reset mid-operation aborts the operation and discards partial results. There is no partial output.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `out_vec`=0.
- Accept edge at cycle T. Lanes are written on edges T+1 … T+LANES. `out_valid` is high from the cycle after edge T+LANES.
- Latency is LANES+1 cycles from the accept edge to `out_valid`; default 5.
- Throughput is one operation per LANES+2 cycles when `out_ready` is held high.
- `out_valid`, `out_vec`, `in_ready` and `busy` are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_vec` and `out_valid` are stable every cycle.
- `rst` has priority over every handshake in the same cycle.

## Test plan
- Left shift, shamt=1:
  - Stimulus: `in_vec`=0x01FF801B, `in_dir`=0.
  - Response: `out_vec`=0x02FE0036; `out_valid` rises exactly 5 cycles after the accept edge.
- Shift-amount sweep, left:
  - Stimulus: `in_shamt` = 0, 1, 2, …, 8, then 255, on the same vector.
  - Response: shamt 0 gives 0x01FF801B; shamt ≥ 8 gives 0x00000000; every other value matches the per-lane `<<` reference model.
- Right shift, shamt=3:
  - Stimulus: `in_vec`=0x01FF801B, `in_dir`=1.
  - Response: `out_vec`=0x001F1003.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 4 cycles in DONE; change `in_vec` and `in_valid` meanwhile.
  - Response: `out_vec` is unchanged and `in_ready`=0 throughout; after the handshake, `in_ready`=1 on the next cycle.
- Reset mid-SHIFT:
  - Stimulus: assert `rst` for 1 cycle after 2 lanes have been written.
  - Response: next cycle IDLE, `out_vec`=0, `out_valid`=0; a fresh operation then completes correctly.
- Back-to-back operations:
  - Stimulus: 3 operations with `in_valid` and `out_ready` held high.
  - Response: results arrive in order, spaced 6 cycles apart; no lane is mixed between operations.
